// File: rtl/ins_mem_ctrl.sv
// Direct-mapped, one-word-per-line instruction fetch controller with a backing-memory refill path.
// Optional hit/miss statistics counters are built when INS_MEM_CTRL_STATS_EN is defined.
module ins_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_COUNT = 16
) (
  input  logic                  ins_mem_clock_in,
  input  logic                  ins_mem_reset_in,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] addr_in,
  input  logic                  flush_in,
  output logic                  ready_out,
  output logic                  data_valid_out,
  output logic                  hit_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  mem_req_out,
  output logic [DATA_WIDTH-1:0] mem_addr_out,
  input  logic                  mem_ack_in,
  input  logic [DATA_WIDTH-1:0] mem_data_in
`ifdef INS_MEM_CTRL_STATS_EN
  ,
  output logic [31:0]           hit_count_out,
  output logic [31:0]           miss_count_out
`endif
);

  localparam int IDX_W = $clog2(LINE_COUNT);
  localparam int WA_W  = DATA_WIDTH - 2;
  localparam int TAG_W = WA_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    REFILL  = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_flush_pend;
  logic [LINE_COUNT-1:0] r_valid;
  logic [WA_W-1:0]       r_waddr;
  logic [TAG_W-1:0]      r_tag  [LINE_COUNT];
  logic [DATA_WIDTH-1:0] r_word [LINE_COUNT];

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_fill;
  logic                  w_unused;

  // Word address of the captured request, split into line index and tag.
  assign w_idx    = r_waddr[IDX_W-1:0];
  assign w_tag    = r_waddr[WA_W-1:IDX_W];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_ready  = ins_mem_reset_in && (r_state == IDLE) && !r_flush_pend && !flush_in;
  assign w_accept = w_ready && valid_in;
  assign w_fill   = ins_mem_reset_in && (r_state == REFILL) && mem_ack_in;
  assign w_unused = ^addr_in[1:0];

  assign ready_out = w_ready;

  // Control FSM with registered outputs.
  always_ff @(posedge ins_mem_clock_in) begin
    if (!ins_mem_reset_in) begin
      r_state        <= IDLE;
      r_flush_pend   <= 1'b0;
      r_valid        <= '0;
      data_valid_out <= 1'b0;
      hit_out        <= 1'b0;
      data_out       <= '0;
      mem_req_out    <= 1'b0;
      mem_addr_out   <= '0;
    end else begin
      data_valid_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (flush_in || r_flush_pend) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end else if (valid_in) begin
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            data_out       <= r_word[w_idx];
            hit_out        <= 1'b1;
            data_valid_out <= 1'b1;
            r_state        <= RESPOND;
          end else begin
            mem_req_out  <= 1'b1;
            mem_addr_out <= {r_waddr, 2'b00};
            r_state      <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack_in) begin
            r_valid[w_idx] <= 1'b1;
            data_out       <= mem_data_in;
            hit_out        <= 1'b0;
            data_valid_out <= 1'b1;
            mem_req_out    <= 1'b0;
            r_state        <= RESPOND;
          end
        end
        RESPOND: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // A flush arriving mid-transaction is deferred to the next IDLE cycle.
      if (flush_in && (r_state != IDLE)) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  // Request address and line storage; only the valid bits need a reset.
  always_ff @(posedge ins_mem_clock_in) begin
    if (w_accept) begin
      r_waddr <= addr_in[DATA_WIDTH-1:2];
    end
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_word[w_idx] <= mem_data_in;
    end
  end

`ifdef INS_MEM_CTRL_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One count per LOOKUP decision; flush leaves the statistics intact.
  always_ff @(posedge ins_mem_clock_in) begin
    if (!ins_mem_reset_in) begin
      hit_count_out  <= '0;
      miss_count_out <= '0;
    end else if (r_state == LOOKUP) begin
      if (w_hit) begin
        hit_count_out <= sat_inc(hit_count_out);
      end else begin
        miss_count_out <= sat_inc(miss_count_out);
      end
    end
  end
`else
  // Statistics disabled: no counters or count ports are built.
`endif

endmodule

// File: tb/tb_ins_mem_ctrl.sv
// Directed self-checking bench for ins_mem_ctrl: cold miss, hit, conflict replacement,
// flush priority and deferral, and reset during refill.
module tb_ins_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] addr_in;
  logic        flush_in;
  logic        ready_out;
  logic        data_valid_out;
  logic        hit_out;
  logic [31:0] data_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_ack_in;
  logic [31:0] mem_data_in;
`ifdef INS_MEM_CTRL_STATS_EN
  logic [31:0] hit_count_out;
  logic [31:0] miss_count_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ins_mem_ctrl #(.DATA_WIDTH(32), .LINE_COUNT(16)) dut (
    .ins_mem_clock_in (clk),
    .ins_mem_reset_in (rst_n),
    .valid_in         (valid_in),
    .addr_in          (addr_in),
    .flush_in         (flush_in),
    .ready_out        (ready_out),
    .data_valid_out   (data_valid_out),
    .hit_out          (hit_out),
    .data_out         (data_out),
    .mem_req_out      (mem_req_out),
    .mem_addr_out     (mem_addr_out),
    .mem_ack_in       (mem_ack_in),
    .mem_data_in      (mem_data_in)
`ifdef INS_MEM_CTRL_STATS_EN
    ,
    .hit_count_out    (hit_count_out),
    .miss_count_out   (miss_count_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Request that must miss: refill address check, ack after dly extra cycles, miss response.
  task automatic fetch_miss(input string tag, input logic [31:0] a, input logic [31:0] d, input int dly);
    valid_in = 1'b1;
    addr_in  = a;
    step();
    valid_in = 1'b0;
    chk({tag, "_lookup_noreq"}, {31'd0, mem_req_out}, 32'd0);
    step();
    chk({tag, "_req"}, {31'd0, mem_req_out}, 32'd1);
    chk({tag, "_maddr"}, mem_addr_out, {a[31:2], 2'b00});
    repeat (dly) step();
    chk({tag, "_req_held"}, {31'd0, mem_req_out}, 32'd1);
    mem_ack_in  = 1'b1;
    mem_data_in = d;
    step();
    mem_ack_in  = 1'b0;
    mem_data_in = 32'h0;
    chk({tag, "_dv"}, {31'd0, data_valid_out}, 32'd1);
    chk({tag, "_hit"}, {31'd0, hit_out}, 32'd0);
    chk({tag, "_data"}, data_out, d);
    chk({tag, "_req_drop"}, {31'd0, mem_req_out}, 32'd0);
    step();
    chk({tag, "_dv_end"}, {31'd0, data_valid_out}, 32'd0);
    chk({tag, "_data_hold"}, data_out, d);
  endtask

  // Request that must hit: no backing-memory traffic, response in the RESPOND cycle.
  task automatic fetch_hit(input string tag, input logic [31:0] a, input logic [31:0] d);
    valid_in = 1'b1;
    addr_in  = a;
    step();
    valid_in = 1'b0;
    chk({tag, "_dv_early"}, {31'd0, data_valid_out}, 32'd0);
    step();
    chk({tag, "_dv"}, {31'd0, data_valid_out}, 32'd1);
    chk({tag, "_hit"}, {31'd0, hit_out}, 32'd1);
    chk({tag, "_data"}, data_out, d);
    chk({tag, "_noreq"}, {31'd0, mem_req_out}, 32'd0);
    step();
    chk({tag, "_dv_end"}, {31'd0, data_valid_out}, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    valid_in    = 1'b0;
    addr_in     = 32'h0;
    flush_in    = 1'b0;
    mem_ack_in  = 1'b0;
    mem_data_in = 32'h0;

    // Reset state.
    repeat (3) step();
    chk("rst_ready", {31'd0, ready_out}, 32'd0);
    chk("rst_dv", {31'd0, data_valid_out}, 32'd0);
    chk("rst_hit", {31'd0, hit_out}, 32'd0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_req", {31'd0, mem_req_out}, 32'd0);
    chk("rst_maddr", mem_addr_out, 32'h0);
`ifdef INS_MEM_CTRL_STATS_EN
    chk("rst_hitcnt", hit_count_out, 32'd0);
    chk("rst_misscnt", miss_count_out, 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, ready_out}, 32'd1);

    // Stray ack in IDLE must be ignored.
    mem_ack_in  = 1'b1;
    mem_data_in = 32'hFFFF_0000;
    step();
    mem_ack_in  = 1'b0;
    chk("idle_ack_dv", {31'd0, data_valid_out}, 32'd0);
    chk("idle_ack_data", data_out, 32'h0);

    // Cold miss, then hit on the same word with different byte offset.
    fetch_miss("cold", 32'h0000_0040, 32'hDEAD_BEEF, 2);
    chk("cold_ready", {31'd0, ready_out}, 32'd1);
    fetch_hit("rehit", 32'h0000_0042, 32'hDEAD_BEEF);

    // Conflict on index 0: 0x80 evicts 0x40, which then misses again.
    fetch_miss("conf80", 32'h0000_0080, 32'h1234_5678, 0);
    fetch_miss("conf40", 32'h0000_0040, 32'hCAFE_F00D, 1);
`ifdef INS_MEM_CTRL_STATS_EN
    chk("stat_hit", hit_count_out, 32'd1);
    chk("stat_miss", miss_count_out, 32'd3);
`endif

    // Flush and valid together in IDLE: flush wins, request not taken.
    valid_in = 1'b1;
    flush_in = 1'b1;
    addr_in  = 32'h0000_0040;
    #1;
    chk("flush_ready", {31'd0, ready_out}, 32'd0);
    step();
    valid_in = 1'b0;
    flush_in = 1'b0;
    #1;
    chk("flush_noaccept", {31'd0, ready_out}, 32'd1);
    step();
    chk("flush_no_dv", {31'd0, data_valid_out}, 32'd0);
    chk("flush_no_req", {31'd0, mem_req_out}, 32'd0);
    fetch_miss("postflush40", 32'h0000_0040, 32'h0BAD_F00D, 0);
    fetch_miss("postflush80", 32'h0000_0080, 32'h1234_5678, 0);

    // Flush during LOOKUP: in-flight hit completes, flush applied on next IDLE cycle.
    valid_in = 1'b1;
    addr_in  = 32'h0000_0080;
    step();
    valid_in = 1'b0;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    chk("pend_dv", {31'd0, data_valid_out}, 32'd1);
    chk("pend_hit", {31'd0, hit_out}, 32'd1);
    chk("pend_data", data_out, 32'h1234_5678);
    step();
    chk("pend_ready0", {31'd0, ready_out}, 32'd0);
    step();
    chk("pend_ready1", {31'd0, ready_out}, 32'd1);
    fetch_miss("pend_miss80", 32'h0000_0080, 32'h8765_4321, 0);

    // Reset during REFILL: request dropped, late ack must not fill a line.
    valid_in = 1'b1;
    addr_in  = 32'h0000_0100;
    step();
    valid_in = 1'b0;
    step();
    chk("rr_req", {31'd0, mem_req_out}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("rr_req_drop", {31'd0, mem_req_out}, 32'd0);
    chk("rr_maddr", mem_addr_out, 32'h0);
    chk("rr_ready", {31'd0, ready_out}, 32'd0);
    rst_n       = 1'b1;
    mem_ack_in  = 1'b1;
    mem_data_in = 32'h5555_5555;
    step();
    mem_ack_in  = 1'b0;
    mem_data_in = 32'h0;
    chk("rr_no_dv", {31'd0, data_valid_out}, 32'd0);
    chk("rr_no_req", {31'd0, mem_req_out}, 32'd0);
    chk("rr_data", data_out, 32'h0);
    fetch_miss("rr_miss", 32'h0000_0100, 32'hA5A5_5A5A, 0);
`ifdef INS_MEM_CTRL_STATS_EN
    chk("rr_stat_hit", hit_count_out, 32'd0);
    chk("rr_stat_miss", miss_count_out, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
